wb_commit_unit: RTL and testbench

//  Write-back stage: MEM/WB pipeline register, load-data wait, byte-lane alignment and commit.

---
 rtl/wb_commit_unit_pkg.sv | 13 +
 rtl/wb_commit_unit_load_align.sv | 21 ++
 rtl/wb_commit_unit.sv | 127 ++++++++++++
 tb/tb_wb_commit_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_unit_pkg.sv
// wb_commit_unit_pkg: shared widths, load-type encodings and WB FSM states
package wb_commit_unit_pkg;
    localparam int DW = 32;
    localparam int RAW = 7;
    typedef enum logic [2:0] {
        MRT_LW  = 3'd0,
        MRT_LB  = 3'd1,
        MRT_LBU = 3'd2,
        MRT_LH  = 3'd3,
        MRT_LHU = 3'd4
    } mrt_e;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} wb_state_e;
endpackage

// File: rtl/wb_commit_unit_load_align.sv
// wb_commit_unit_load_align: little-endian lane select and sign/zero extension of load data
module wb_commit_unit_load_align #(
    parameter int DW = wb_commit_unit_pkg::DW
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr,
    input  logic [2:0]    mrt,
    output logic [DW-1:0] data
);
    import wb_commit_unit_pkg::*;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        data = mrt == MRT_LB  ? {{(DW-8){b[7]}}, b} :
               mrt == MRT_LBU ? {{(DW-8){1'b0}}, b} :
               mrt == MRT_LH  ? {{(DW-16){h[15]}}, h} :
               mrt == MRT_LHU ? {{(DW-16){1'b0}}, h} : rdata;
    end
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: MEM/WB register, load-data wait FSM, alignment and register-file commit
module wb_commit_unit #(
    parameter int DW  = wb_commit_unit_pkg::DW,
    parameter int RAW = wb_commit_unit_pkg::RAW,
    parameter int HLW = 2*DW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallW,
    input  logic           flushW,
    input  logic           validM,
    input  logic           RegWriteM,
    input  logic           MemtoRegM,
    input  logic [2:0]     MemReadTypeM,
    input  logic [RAW-1:0] WriteRegM,
    input  logic [DW-1:0]  ALUoutM,
    input  logic           HI_LO_write_enableM,
    input  logic [HLW-1:0] HI_LO_dataM,
    input  logic [DW-1:0]  PCM,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_data_ok,
    output logic           RegWriteW,
    output logic [RAW-1:0] WriteRegW,
    output logic [DW-1:0]  ResultW,
    output logic           HI_LO_write_enable_from_WB,
    output logic [HLW-1:0] HI_LO_data,
    output logic [DW-1:0]  PCW,
    output logic           load_stall_req
);
    import wb_commit_unit_pkg::*;
    wb_state_e      state, state_n;
    logic           valid_r, reg_write_r, mem_to_reg_r, hl_we_r;
    logic [2:0]     mrt_r;
    logic [RAW-1:0] write_reg_r;
    logic [DW-1:0]  alu_out_r, pc_r, rdata_buf, load_data;
    logic [HLW-1:0] hl_data_r;
    logic           orphan, orphan_n, committed;
    logic           pending, own_ok, commit_ok, capture, wb_load;

    wb_commit_unit_load_align #(.DW(DW)) u_load_align (
        .rdata (state == DONE ? rdata_buf : mem_rdata),
        .addr  (alu_out_r[1:0]),
        .mrt   (mrt_r),
        .data  (load_data)
    );

    // own_ok: a data_ok that belongs to the load in WB rather than a dropped one
    always_comb begin
        pending        = valid_r & mem_to_reg_r & !committed;
        own_ok         = mem_data_ok & !orphan;
        state_n        = state;
        load_stall_req = 1'b0;
        commit_ok      = !committed & !mem_to_reg_r;
        capture        = 1'b0;
        orphan_n       = orphan & !mem_data_ok;
        case (state)
            IDLE: if (pending) begin
                if (own_ok) begin
                    commit_ok = !stallW;
                    capture   = stallW & !flushW;
                    state_n   = (stallW & !flushW) ? DONE : IDLE;
                end else begin
                    load_stall_req = 1'b1;
                    if (flushW) orphan_n = 1'b1;
                    else state_n = WAIT;
                end
            end
            WAIT: begin
                load_stall_req = 1'b1;
                if (flushW) begin
                    state_n  = IDLE;
                    orphan_n = orphan | !mem_data_ok;
                end else if (own_ok) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                commit_ok = !flushW & !stallW;
                state_n   = (stallW & !flushW) ? DONE : IDLE;
            end
            default: state_n = IDLE;
        endcase
        wb_load = flushW | (!stallW & !load_stall_req);
    end

    assign RegWriteW                  = valid_r & reg_write_r & (|write_reg_r) & commit_ok;
    assign WriteRegW                  = write_reg_r;
    assign ResultW                    = mem_to_reg_r ? load_data : alu_out_r;
    assign HI_LO_write_enable_from_WB = valid_r & hl_we_r;
    assign HI_LO_data                 = hl_data_r;
    assign PCW                        = pc_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            orphan       <= 1'b0;
            committed    <= 1'b0;
            rdata_buf    <= '0;
            valid_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            mrt_r        <= '0;
            write_reg_r  <= '0;
            alu_out_r    <= '0;
            hl_we_r      <= 1'b0;
            hl_data_r    <= '0;
            pc_r         <= '0;
        end else begin
            state     <= state_n;
            orphan    <= orphan_n;
            committed <= wb_load ? 1'b0 : committed | (valid_r & commit_ok);
            if (capture) rdata_buf <= mem_rdata;
            if (wb_load) begin
                valid_r      <= validM & !flushW;
                reg_write_r  <= RegWriteM;
                mem_to_reg_r <= MemtoRegM;
                mrt_r        <= MemReadTypeM;
                write_reg_r  <= WriteRegM;
                alu_out_r    <= ALUoutM;
                hl_we_r      <= HI_LO_write_enableM;
                hl_data_r    <= HI_LO_dataM;
                pc_r         <= PCM;
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: scoreboard bench for the write-back commit unit
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallW = 1'b0, flushW = 1'b0, validM = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0;
    logic [2:0]  MemReadTypeM = 3'd0;
    logic [6:0]  WriteRegM = 7'd0;
    logic [31:0] ALUoutM = 32'd0, PCM = 32'h100, mem_rdata = 32'd0;
    logic        HI_LO_write_enableM = 1'b0, mem_data_ok = 1'b0;
    logic [63:0] HI_LO_dataM = 64'd0;
    logic        RegWriteW, HI_LO_write_enable_from_WB, load_stall_req;
    logic [6:0]  WriteRegW;
    logic [31:0] ResultW, PCW;
    logic [63:0] HI_LO_data;
    logic [38:0] sb[$];
    int          n_checks = 0, n_errors = 0;

    wb_commit_unit dut (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReadTypeM(MemReadTypeM),
        .WriteRegM(WriteRegM), .ALUoutM(ALUoutM), .HI_LO_write_enableM(HI_LO_write_enableM),
        .HI_LO_dataM(HI_LO_dataM), .PCM(PCM), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .HI_LO_write_enable_from_WB(HI_LO_write_enable_from_WB), .HI_LO_data(HI_LO_data),
        .PCW(PCW), .load_stall_req(load_stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic m2r, input logic [2:0] mrt,
                         input logic [6:0] wr, input logic [31:0] alu,
                         input logic hl_we, input logic [63:0] hl);
        validM = 1'b1; RegWriteM = rw; MemtoRegM = m2r; MemReadTypeM = mrt;
        WriteRegM = wr; ALUoutM = alu; HI_LO_write_enableM = hl_we; HI_LO_dataM = hl;
        PCM = PCM + 32'd4;
        cyc();
        validM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; HI_LO_write_enableM = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && RegWriteW) begin
            if (sb.size() == 0) check("sb_unexpected", 64'(sb.size()), 64'd1);
            else begin
                logic [38:0] e;
                e = sb.pop_front();
                check("sb_reg", 64'(WriteRegW), 64'(e[38:32]));
                check("sb_data", 64'(ResultW), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(); cyc();
        @(negedge clk);
        check("rst_we", 64'(RegWriteW), 64'd0);
        check("rst_stall", 64'(load_stall_req), 64'd0);
        check("rst_result", 64'(ResultW), 64'd0);
        check("rst_hl", HI_LO_data, 64'd0);
        rst = 1'b1;
        cyc();
        // ALU op commits the cycle after issue
        sb.push_back({7'd5, 32'h1234});
        issue(1'b1, 1'b0, 3'd0, 7'd5, 32'h1234, 1'b0, 64'd0);
        @(negedge clk);
        check("alu_we", 64'(RegWriteW), 64'd1);
        check("alu_stall", 64'(load_stall_req), 64'd0);
        check("alu_pc", 64'(PCW), 64'h104);
        cyc();
        // lb / lbu with same-cycle data
        for (int i = 0; i < 2; i++) begin
            sb.push_back({7'd8, i == 0 ? 32'hFFFF_FF80 : 32'h0000_0080});
            issue(1'b1, 1'b1, i == 0 ? 3'd1 : 3'd2, 7'd8, 32'h0000_0103, 1'b0, 64'd0);
            mem_rdata = 32'h80FF_0000; mem_data_ok = 1'b1;
            @(negedge clk);
            check("lb_stall", 64'(load_stall_req), 64'd0);
            cyc();
            mem_data_ok = 1'b0;
        end
        // lhu with late data
        sb.push_back({7'd9, 32'h0000_BEEF});
        issue(1'b1, 1'b1, 3'd4, 7'd9, 32'h0000_2002, 1'b0, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lhu_stall", 64'(load_stall_req), 64'd1);
            check("lhu_hold", 64'(RegWriteW), 64'd0);
            if (k == 2) begin mem_rdata = 32'hBEEF_1234; mem_data_ok = 1'b1; end
            cyc();
            mem_data_ok = 1'b0;
        end
        @(negedge clk);
        check("lhu_done_stall", 64'(load_stall_req), 64'd0);
        check("lhu_done_we", 64'(RegWriteW), 64'd1);
        cyc();
        // load to $0, then HI/LO write
        issue(1'b1, 1'b1, 3'd0, 7'd0, 32'h0000_0040, 1'b0, 64'd0);
        mem_rdata = 32'h1111_2222; mem_data_ok = 1'b1;
        @(negedge clk);
        check("r0_we", 64'(RegWriteW), 64'd0);
        check("r0_stall", 64'(load_stall_req), 64'd0);
        cyc();
        mem_data_ok = 1'b0;
        issue(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 1'b1, 64'h1_0000_0002);
        @(negedge clk);
        check("hl_we", 64'(HI_LO_write_enable_from_WB), 64'd1);
        check("hl_data", HI_LO_data, 64'h1_0000_0002);
        check("hl_stall", 64'(load_stall_req), 64'd0);
        cyc();
        // ALU op under stallW commits exactly once
        sb.push_back({7'd4, 32'hCAFE});
        issue(1'b1, 1'b0, 3'd0, 7'd4, 32'hCAFE, 1'b0, 64'd0);
        stallW = 1'b1;
        cyc();
        @(negedge clk);
        check("stall_once", 64'(RegWriteW), 64'd0);
        stallW = 1'b0;
        cyc();
        // flush in WAIT leaves an orphan data_ok that the next lw must skip
        issue(1'b1, 1'b1, 3'd0, 7'd10, 32'h0000_0040, 1'b0, 64'd0);
        @(negedge clk);
        check("orph_stall0", 64'(load_stall_req), 64'd1);
        cyc();
        flushW = 1'b1;
        cyc();
        flushW = 1'b0;
        @(negedge clk);
        check("orph_flushed", 64'(load_stall_req), 64'd0);
        sb.push_back({7'd11, 32'h0000_5555});
        issue(1'b1, 1'b1, 3'd0, 7'd11, 32'h0000_0044, 1'b0, 64'd0);
        @(negedge clk);
        check("orph_new_stall", 64'(load_stall_req), 64'd1);
        cyc();
        mem_rdata = 32'h0000_AAAA; mem_data_ok = 1'b1;
        cyc();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("orph_skip", 64'(load_stall_req), 64'd1);
        mem_rdata = 32'h0000_5555; mem_data_ok = 1'b1;
        cyc();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("orph_done_stall", 64'(load_stall_req), 64'd0);
        cyc();
        // reset asserted while waiting for load data
        issue(1'b1, 1'b1, 3'd0, 7'd12, 32'h0000_0048, 1'b0, 64'd0);
        cyc();
        @(negedge clk);
        check("rstw_stall_pre", 64'(load_stall_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rstw_stall", 64'(load_stall_req), 64'd0);
        check("rstw_we", 64'(RegWriteW), 64'd0);
        check("rstw_wr", 64'(WriteRegW), 64'd0);
        check("rstw_pc", 64'(PCW), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        sb.push_back({7'd3, 32'h77});
        issue(1'b1, 1'b0, 3'd0, 7'd3, 32'h77, 1'b0, 64'd0);
        @(negedge clk);
        check("post_rst_stall", 64'(load_stall_req), 64'd0);
        cyc(); cyc();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
